// File: rtl/controlador_acceso.sv
// Vehicle gate access controller: Moore FSM with PIN-attempt detection and a
// saturating wrong-attempt counter driving the gate commands and the alarms.
module controlador_acceso #(
    parameter logic [15:0] CLAVE_CORRECTA = 16'h1194,
    parameter int unsigned MAX_INTENTOS   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        llegado_vehiculo,
    input  logic [15:0] clave_ingresada,
    input  logic        paso_vehiculo,
    input  logic        boton_reset,
    output logic        abriendo_compuerta,
    output logic        cerrando_compuerta,
    output logic        alarm_pin_incorrecto,
    output logic        alarm_bloqueo,
    output logic [3:0]  intentos_fallidos
);

    localparam int unsigned CLAVE_W = 16;
    localparam int unsigned CNT_W   = 4;

    localparam logic [CNT_W-1:0] CNT_SAT = '1;
    localparam logic [CNT_W-1:0] UMBRAL  = CNT_W'(MAX_INTENTOS);

    typedef enum logic [2:0] {
        ESPERA     = 3'd0,
        ABRIENDO   = 3'd1,
        CERRANDO   = 3'd2,
        ALARMA_PIN = 3'd3,
        BLOQUEO    = 3'd4
    } estado_t;

    estado_t            estado;
    estado_t            estado_sig;
    logic [CLAVE_W-1:0] clave_prev;
    logic               lv_prev;
    logic [CNT_W-1:0]   intentos;
    logic [CNT_W-1:0]   intentos_sig;
    logic [CNT_W-1:0]   intentos_inc;
    logic               intento;
    logic               pin_ok;
    logic               ac_sig;
    logic               cp_sig;
    logic               ai_sig;
    logic               ab_sig;

    // State, history and registered Moore outputs (outputs follow the next state)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado               <= ESPERA;
            clave_prev           <= '0;
            lv_prev              <= 1'b0;
            intentos             <= '0;
            abriendo_compuerta   <= 1'b0;
            cerrando_compuerta   <= 1'b0;
            alarm_pin_incorrecto <= 1'b0;
            alarm_bloqueo        <= 1'b0;
        end else begin
            estado               <= estado_sig;
            clave_prev           <= clave_ingresada;
            lv_prev              <= llegado_vehiculo;
            intentos             <= intentos_sig;
            abriendo_compuerta   <= ac_sig;
            cerrando_compuerta   <= cp_sig;
            alarm_pin_incorrecto <= ai_sig;
            alarm_bloqueo        <= ab_sig;
        end
    end

    // Next-state, counter update and next output decode
    always_comb begin
        estado_sig   = estado;
        intentos_sig = intentos;
        // A new attempt is an LV rise or a PIN change while LV is held
        intento      = llegado_vehiculo && (!lv_prev || (clave_ingresada != clave_prev));
        pin_ok       = (clave_ingresada == CLAVE_CORRECTA);
        intentos_inc = (intentos == CNT_SAT) ? CNT_SAT : intentos + CNT_W'(1);

        case (estado)
            ESPERA: begin
                if (paso_vehiculo) begin
                    estado_sig = BLOQUEO;
                end else if (intento && pin_ok) begin
                    estado_sig   = ABRIENDO;
                    intentos_sig = '0;
                end else if (intento) begin
                    intentos_sig = intentos_inc;
                    if (intentos_inc >= UMBRAL) begin
                        estado_sig = ALARMA_PIN;
                    end
                end
            end
            ABRIENDO: begin
                if (paso_vehiculo && llegado_vehiculo) begin
                    estado_sig = BLOQUEO;
                end else if (paso_vehiculo) begin
                    estado_sig = CERRANDO;
                end
            end
            CERRANDO: begin
                if (paso_vehiculo && llegado_vehiculo) begin
                    estado_sig = BLOQUEO;
                end else if (!paso_vehiculo) begin
                    estado_sig = ESPERA;
                end
            end
            ALARMA_PIN: begin
                if (paso_vehiculo) begin
                    estado_sig = BLOQUEO;
                end else if (boton_reset) begin
                    estado_sig   = ESPERA;
                    intentos_sig = '0;
                end
            end
            BLOQUEO: begin
                if (boton_reset && pin_ok) begin
                    estado_sig   = ESPERA;
                    intentos_sig = '0;
                end
            end
            default: begin
                estado_sig = ESPERA;
            end
        endcase

        ac_sig = (estado_sig == ABRIENDO);
        cp_sig = (estado_sig == CERRANDO) || (estado_sig == BLOQUEO);
        ai_sig = (estado_sig == ALARMA_PIN);
        ab_sig = (estado_sig == BLOQUEO);
    end

    assign intentos_fallidos = intentos;

endmodule

// File: doc/controlador_acceso.md
# controlador_acceso

Gate access controller for the vehicle entrance. It receives the arrival sensor, the passage sensor, the BCD PIN and the reset button, and drives the gate open/close commands and the two alarms. It is the device under test that the existing access stimulus bench drives, and it consumes exactly the signals that bench produces. It is a single Moore FSM with a PIN-attempt detector and a saturating failure counter.

## Interface
- `CLAVE_CORRECTA`, default 16'h1194: valid PIN, 4 BCD digits.
- `MAX_INTENTOS`, default 3: consecutive wrong attempts that raise `alarm_pin_incorrecto`. Legal range 1..15.
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `llegado_vehiculo` in 1: vehicle present at gate (LV), level.
- `clave_ingresada` in 16: entered PIN, BCD, level.
- `paso_vehiculo` in 1: vehicle crossing gate (CV), level.
- `boton_reset` in 1: operator reset button (BR), level.
- `abriendo_compuerta` out 1: gate open command (AC).
- `cerrando_compuerta` out 1: gate close command (CP).
- `alarm_pin_incorrecto` out 1: wrong-PIN alarm (AI).
- `alarm_bloqueo` out 1: tailgate/block alarm (AB).
- `intentos_fallidos` out 4: current wrong-attempt count, for debug and observability.

## Operation
- Registers:
  - `estado`, 3 bits.
  - `clave_prev`, 16 bits: previous-cycle PIN.
  - `lv_prev`: previous-cycle LV.
  - `intentos`, 4 bits, saturating at 15.
- Attempt event (`intento`) is asserted in a cycle when `llegado_vehiculo`=1 AND either (`lv_prev`=0) or (`clave_ingresada` != `clave_prev`).
  - `clave_prev` and `lv_prev` update every cycle, in every state.
- `pin_ok` = (`clave_ingresada` == `CLAVE_CORRECTA`). Full 16-bit compare; no BCD validity check.
- States, with outputs decoded from state only:
  - ESPERA: all four outputs 0.
    - `paso_vehiculo`=1 → BLOQUEO. This has highest priority.
    - else `intento`&`pin_ok` → ABRIENDO, and `intentos` clears to 0.
    - else `intento`&!`pin_ok`: `intentos`+1. If the new value ≥ `MAX_INTENTOS` → ALARMA_PIN, otherwise stay.
  - ABRIENDO: AC=1.
    - `paso_vehiculo`&`llegado_vehiculo` → BLOQUEO (tailgate).
    - else `paso_vehiculo` → CERRANDO.
    - LV may drop and re-rise here; further attempts are ignored.
  - CERRANDO: CP=1.
    - `paso_vehiculo`&`llegado_vehiculo` → BLOQUEO.
    - else `paso_vehiculo`=0 → ESPERA.
  - ALARMA_PIN: AI=1, gate closed. Attempts are ignored and the counter is held.
    - `paso_vehiculo`=1 → BLOQUEO.
    - else `boton_reset`=1 → ESPERA, and `intentos` clears to 0.
  - BLOQUEO: AB=1 and CP=1. Attempts are ignored.
    - `boton_reset`&`pin_ok` → ESPERA, and `intentos` clears to 0.
    - `boton_reset` with a wrong PIN: stay.
- `boton_reset` has no effect in ESPERA, ABRIENDO or CERRANDO.
- Unused state encodings → ESPERA on the next edge.

## Timing
- Reset (`reset`=0): takes effect immediately, independent of `clk`.
  - `estado`=ESPERA, `intentos`=0, `clave_prev`=0, `lv_prev`=0.
  - All outputs 0, and they stay 0 while reset is held.
  - Reset in the middle of a sequence (e.g., in ABRIENDO) drops AC at once.
- All inputs are sampled on the rising edge of `clk`.
- Outputs are registered Moore outputs. They change one edge after the qualifying input edge; there is no combinational input→output path.
- Latency: a correct PIN sampled at edge N gives AC=1 after edge N.
- A PIN held constant while LV stays high counts as one attempt only.
- A PIN change and the LV rise in the same cycle count as one attempt.
- `intentos_fallidos` mirrors `intentos` and updates on the same edge as the state change.
- Simultaneous CV and LV always resolve to BLOQUEO, in every state except BLOQUEO.

## Test plan
1. Reset, then LV=1 with PIN 16'h1194 → AC=1 one edge later, `intentos`=0. Then CV=1, LV=0 → CP=1, AC=0. Then CV=0 → all outputs 0.
2. LV=1, then PIN 16'h1234, then 16'h5678, then 16'h1194 → `intentos` goes 1, 2, then 0 with AC=1, and AI stays 0. Then CV pass → ESPERA.
3. LV=1 with PIN 16'h1234, then 16'h5678, then 16'h9876 → `intentos`=3 and AI=1. Then a 16'h1194 attempt → AI stays 1. Then BR pulse → AI=0, `intentos`=0. Then a correct PIN → AC=1.
4. Correct PIN → AC=1, then CV=1 with LV=1 → AB=1, CP=1, AC=0. Then BR with PIN 16'h5678 → AB stays 1. Then BR with 16'h1194 → all outputs 0.
5. From ESPERA, CV=1 with no LV → AB=1. Also: PIN held at 16'h1234 for 5 cycles with LV=1 → `intentos`=1 only.
6. `reset` asserted asynchronously mid-cycle while in ABRIENDO, and again while in ALARMA_PIN → outputs fall to 0 before the next `clk` edge. After release, the FSM is in ESPERA with `intentos`=0.
